apb3_slave_arbiter: RTL and testbench
=====================================

// Module: apb3_slave_arbiter
// PURPOSE
//  Shares one APB3 slave (the SPI controller) between two APB3 masters: M0 = EMPU APB master
//  (psel1 path), M1 = hardware requester (autonomous SPI sequencer). Each master sees a normal
//  APB3 slave; the arbiter serialises transfers, re-issues each on the slave side and returns
//  registered read data / response. Sits between the EMPU APB port and the SPI controller.
// PARAMETERS
//  ADDR_W          8    APB address width
//  DATA_W          32   APB data width
//  TIMEOUT_CYCLES  256  max ACCESS cycles before forced error (only with APB_ARB_TIMEOUT_EN)
// PORTS
//  clk          in   1       APB clock, all logic rising-edge
//  resetn       in   1       synchronous active-low reset
//  mN_paddr     in   ADDR_W  master N address (N = 0,1; same set of ports per master)
//  mN_psel      in   1       master N select
//  mN_penable   in   1       master N enable
//  mN_pwrite    in   1       master N write
//  mN_pwdata    in   DATA_W  master N write data
//  mN_prdata    out  DATA_W  master N read data, valid with mN_pready
//  mN_pready    out  1       master N ready (one-cycle pulse at completion)
//  mN_pslverr   out  1       master N error, valid with mN_pready
//  s_paddr/s_pwrite/s_pwdata  out  ADDR_W/1/DATA_W  slave request fields (registered)
//  s_psel       out  1       slave select
//  s_penable    out  1       slave enable
//  s_prdata     in   DATA_W  slave read data
//  s_pready     in   1       slave ready
//  s_pslverr    in   1       slave error
//  arb_gnt      out  2       one-hot current owner (bit0 = M0), 0 when IDLE
// BEHAVIOUR
//  - Reset (resetn=0 at edge): all outputs 0, FSM=IDLE, rr pointer favours M0. Mid-transfer
//    reset drops s_psel/s_penable at that edge; the in-flight transfer is lost, no mN_pready.
//  - Request: reqN = mN_psel. Sampled only in IDLE.
//  - Round robin: single request granted directly; both requesting -> master not granted last;
//    after reset M0 wins a tie. Pointer updates on entering DONE.
//  - FSM: IDLE -(any req)-> SETUP -> ACCESS -(s_pready | timeout)-> DONE -> IDLE.
//    IDLE->SETUP: latch paddr/pwrite/pwdata of winner into s_*, s_psel=1, s_penable=0.
//    ACCESS: s_psel=1, s_penable=1, hold until s_pready=1.
//    ACCESS->DONE: capture s_prdata (0 on write) and s_pslverr; s_psel/s_penable=0.
//    DONE: owner's mN_pready=1 with registered prdata/pslverr for exactly one cycle.
//  - Latency: master setup at cycle T -> slave setup T+1, access T+2, zero-wait slave ->
//    mN_pready at T+3. Min 4 cycles per transfer incl. IDLE; back-to-back alternation fair.
//  - Non-owner: mN_pready=0 while its psel held; it simply waits (APB wait states).
//  - Owner drops mN_psel before DONE (protocol violation): slave transfer still completes,
//    result discarded, no pready pulse to that master.
//  - mN_prdata/mN_pslverr are 0 except during that master's DONE cycle.
// CONFIGURATION
//  APB_ARB_TIMEOUT_EN defined: cycle counter runs in ACCESS; if s_pready not seen by
//   TIMEOUT_CYCLES ACCESS cycles, force DONE with pslverr=1, prdata=0, s_psel dropped.
//  Undefined: no counter; ACCESS waits indefinitely for s_pready.
// STRUCTURE
//  - Package apb_arb_pkg: FSM state encoding (IDLE/SETUP/ACCESS/DONE), master index constants.
//  - Sub-module apb_arb_rr_pick: 2-input round-robin picker (req[1:0], last -> gnt onehot).
//  - Top holds FSM, request/response registers, optional timeout counter.
// TESTING
//  1 M0 write 0x04<=0xDEADBEEF, zero-wait slave -> s_psel at T+1, s_penable T+2, m0_pready T+3.
//  2 M0 and M1 request same cycle after reset -> M0 served first, M1 next; then both again
//    -> M0 then M1 order alternates correctly (M1 wins next tie after M0 last).
//  3 M1 read 0x08, slave 3 wait states returning 0x5A5A0001 -> m1_prdata=0x5A5A0001 with
//    m1_pready at T+6, m0_pready stays 0 throughout.
//  4 Slave pready with pslverr=1 -> owner's pslverr=1 for the one pready cycle only.
//  5 resetn=0 during ACCESS -> next edge s_psel=0, arb_gnt=0, no pready to owner.
//  6 APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, s_pready stuck 0 -> DONE after 16 ACCESS
//    cycles, pslverr=1, prdata=0; without macro, bus still waiting after 1000 cycles.

Source files
------------

// File: rtl/apb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb_pkg
// Purpose  : Shared definitions for the two-master APB3 slave arbiter.
//            FSM state encoding and master index constants.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

    // Arbiter FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    // Master indices (M0 = EMPU APB master, M1 = SPI sequencer)
    localparam logic C_M0_IDX = 1'b0;
    localparam logic C_M1_IDX = 1'b1;

endpackage
`default_nettype wire

// File: rtl/apb_arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb_rr_pick
// Purpose  : Two-input round-robin picker. A lone request is granted
//            directly; on a tie the master that was NOT granted last wins.
// Ports    : i_req  [1:0] request vector (bit0 = M0)
//            i_last       index of the master granted last
//            o_gnt  [1:0] one-hot grant, 0 when no request
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module apb_arb_rr_pick
    import apb_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_last == C_M0_IDX) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/apb3_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb3_slave_arbiter
// Purpose  : Shares one APB3 slave (SPI controller) between two APB3 masters
//            (M0 = EMPU, M1 = hardware sequencer). Transfers are serialised,
//            re-issued on the slave side from registers, and the read data /
//            error is returned registered as a one-cycle pready pulse.
// Ports    : clk, resetn (synchronous, active low)
//            mN_paddr/psel/penable/pwrite/pwdata  in  master N request
//            mN_prdata/pready/pslverr             out master N response
//            s_paddr/s_pwrite/s_pwdata/s_psel/s_penable out slave request
//            s_prdata/s_pready/s_pslverr          in  slave response
//            arb_gnt [1:0]                        out one-hot current owner
// Config   : APB_ARB_TIMEOUT_EN - when defined, an ACCESS phase lasting
//            TIMEOUT_CYCLES cycles without s_pready is forced to complete
//            with pslverr=1 and prdata=0.
// Revision : 1.0 - initial release
// ============================================================================
module apb3_slave_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
`ifdef APB_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] m0_paddr,
    input  logic              m0_psel,
    input  logic              m0_penable,
    input  logic              m0_pwrite,
    input  logic [DATA_W-1:0] m0_pwdata,
    output logic [DATA_W-1:0] m0_prdata,
    output logic              m0_pready,
    output logic              m0_pslverr,
    input  logic [ADDR_W-1:0] m1_paddr,
    input  logic              m1_psel,
    input  logic              m1_penable,
    input  logic              m1_pwrite,
    input  logic [DATA_W-1:0] m1_pwdata,
    output logic [DATA_W-1:0] m1_prdata,
    output logic              m1_pready,
    output logic              m1_pslverr,
    output logic [ADDR_W-1:0] s_paddr,
    output logic              s_pwrite,
    output logic [DATA_W-1:0] s_pwdata,
    output logic              s_psel,
    output logic              s_penable,
    input  logic [DATA_W-1:0] s_prdata,
    input  logic              s_pready,
    input  logic              s_pslverr,
    output logic [1:0]        arb_gnt
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              drop_q, drop_d;
    logic [ADDR_W-1:0] s_paddr_q, s_paddr_d;
    logic              s_pwrite_q, s_pwrite_d;
    logic [DATA_W-1:0] s_pwdata_q, s_pwdata_d;
    logic              s_psel_q, s_psel_d;
    logic              s_penable_q, s_penable_d;
    logic [1:0]        pready_q, pready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [1:0]        w_req;
    logic [1:0]        w_pick;
    logic              w_owner_psel;
    logic              w_timeout;
    logic              w_finish;
    logic              w_unused;

    // Requests are psel only; penable carries no arbitration information.
    assign w_req        = {m1_psel, m0_psel};
    assign w_unused     = ^{m0_penable, m1_penable};
    assign w_owner_psel = (owner_q == C_M1_IDX) ? m1_psel : m0_psel;
    assign w_finish     = (state_q == ST_ACCESS) && (s_pready || w_timeout);

    apb_arb_rr_pick u_rr_pick (
        .i_req  (w_req),
        .i_last (last_q),
        .o_gnt  (w_pick)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int C_CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [C_CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts ACCESS cycles already elapsed; the last permitted cycle
    // is the one where it equals TIMEOUT_CYCLES-1.
    assign w_timeout = (state_q == ST_ACCESS) &&
                       (cnt_q == C_CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == ST_ACCESS && !w_finish) begin
            cnt_d = cnt_q + C_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (|w_req) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (w_finish) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        owner_d     = owner_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        drop_d      = drop_q;
        s_paddr_d   = s_paddr_q;
        s_pwrite_d  = s_pwrite_q;
        s_pwdata_d  = s_pwdata_q;
        s_psel_d    = s_psel_q;
        s_penable_d = s_penable_q;
        pready_d    = 2'b00;
        rdata_d     = '0;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|w_req) begin
                    owner_d     = w_pick[1] ? C_M1_IDX : C_M0_IDX;
                    gnt_d       = w_pick;
                    drop_d      = 1'b0;
                    s_paddr_d   = w_pick[1] ? m1_paddr  : m0_paddr;
                    s_pwrite_d  = w_pick[1] ? m1_pwrite : m0_pwrite;
                    s_pwdata_d  = w_pick[1] ? m1_pwdata : m0_pwdata;
                    s_psel_d    = 1'b1;
                    s_penable_d = 1'b0;
                end
            end
            ST_SETUP: begin
                s_penable_d = 1'b1;
                if (!w_owner_psel) drop_d = 1'b1;
            end
            ST_ACCESS: begin
                if (!w_owner_psel) drop_d = 1'b1;
                if (w_finish) begin
                    s_psel_d    = 1'b0;
                    s_penable_d = 1'b0;
                    last_d      = owner_q;
                    // An owner that abandoned its transfer gets no pulse.
                    pready_d[owner_q] = !drop_q && w_owner_psel;
                    // A real slave response takes priority over a timeout.
                    rdata_d = (s_pready && !s_pwrite_q) ? s_prdata : '0;
                    err_d   = s_pready ? s_pslverr : 1'b1;
                end
            end
            ST_DONE: begin
                gnt_d = 2'b00;
            end
            default: begin
                gnt_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner_q     <= C_M0_IDX;
            gnt_q       <= 2'b00;
            last_q      <= C_M1_IDX;  // M0 wins the first tie
            drop_q      <= 1'b0;
            s_paddr_q   <= '0;
            s_pwrite_q  <= 1'b0;
            s_pwdata_q  <= '0;
            s_psel_q    <= 1'b0;
            s_penable_q <= 1'b0;
            pready_q    <= 2'b00;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            drop_q      <= drop_d;
            s_paddr_q   <= s_paddr_d;
            s_pwrite_q  <= s_pwrite_d;
            s_pwdata_q  <= s_pwdata_d;
            s_psel_q    <= s_psel_d;
            s_penable_q <= s_penable_d;
            pready_q    <= pready_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Response fields are only visible to the master being answered.
    assign m0_pready  = pready_q[0];
    assign m0_prdata  = pready_q[0] ? rdata_q : '0;
    assign m0_pslverr = pready_q[0] & err_q;
    assign m1_pready  = pready_q[1];
    assign m1_prdata  = pready_q[1] ? rdata_q : '0;
    assign m1_pslverr = pready_q[1] & err_q;

    assign s_paddr   = s_paddr_q;
    assign s_pwrite  = s_pwrite_q;
    assign s_pwdata  = s_pwdata_q;
    assign s_psel    = s_psel_q;
    assign s_penable = s_penable_q;
    assign arb_gnt   = gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_apb3_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb3_slave_arbiter
// Purpose  : Directed self-checking bench for apb3_slave_arbiter. The bench
//            plays both masters and the slave; expected values are fixed
//            constants worked out by hand from the cycle timing.
// Config   : APB_ARB_TIMEOUT_EN selects the timeout scenario (TIMEOUT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb3_slave_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  m0_paddr, m1_paddr, s_paddr;
    logic        m0_psel, m0_penable, m0_pwrite;
    logic        m1_psel, m1_penable, m1_pwrite;
    logic [31:0] m0_pwdata, m1_pwdata, s_pwdata;
    logic [31:0] m0_prdata, m1_prdata, s_prdata;
    logic        m0_pready, m0_pslverr, m1_pready, m1_pslverr;
    logic        s_pwrite, s_psel, s_penable, s_pready, s_pslverr;
    logic [1:0]  arb_gnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb3_slave_arbiter #(
        .ADDR_W(8),
        .DATA_W(32)
`ifdef APB_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .m0_paddr   (m0_paddr),
        .m0_psel    (m0_psel),
        .m0_penable (m0_penable),
        .m0_pwrite  (m0_pwrite),
        .m0_pwdata  (m0_pwdata),
        .m0_prdata  (m0_prdata),
        .m0_pready  (m0_pready),
        .m0_pslverr (m0_pslverr),
        .m1_paddr   (m1_paddr),
        .m1_psel    (m1_psel),
        .m1_penable (m1_penable),
        .m1_pwrite  (m1_pwrite),
        .m1_pwdata  (m1_pwdata),
        .m1_prdata  (m1_prdata),
        .m1_pready  (m1_pready),
        .m1_pslverr (m1_pslverr),
        .s_paddr    (s_paddr),
        .s_pwrite   (s_pwrite),
        .s_pwdata   (s_pwdata),
        .s_psel     (s_psel),
        .s_penable  (s_penable),
        .s_prdata   (s_prdata),
        .s_pready   (s_pready),
        .s_pslverr  (s_pslverr),
        .arb_gnt    (arb_gnt)
    );

    // Advance to just after the next rising edge: outputs of the new cycle
    // are stable there and inputs for that cycle are applied there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic seen;

    initial begin
        resetn = 1'b0;
        m0_paddr = '0; m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_pwdata = '0;
        m1_paddr = '0; m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_pwdata = '0;
        s_prdata = '0; s_pready = 0; s_pslverr = 0;
        seen = 1'b0;

        // ---------------- reset state ----------------
        step(); step();
        chk("rst_s_psel", 32'(s_psel), 32'd0);
        chk("rst_s_penable", 32'(s_penable), 32'd0);
        chk("rst_arb_gnt", 32'(arb_gnt), 32'd0);
        chk("rst_m0_pready", 32'(m0_pready), 32'd0);
        chk("rst_s_paddr", 32'(s_paddr), 32'd0);
        resetn = 1'b1;
        step();

        // ---------------- 1: M0 write, zero-wait slave ----------------
        m0_psel = 1; m0_penable = 0; m0_pwrite = 1; m0_paddr = 8'h04; m0_pwdata = 32'hDEADBEEF;
        s_pready = 1; s_prdata = 32'hCAFE0000;
        step();                                   // T+1: slave SETUP
        chk("t1_s_psel", 32'(s_psel), 32'd1);
        chk("t1_s_penable_setup", 32'(s_penable), 32'd0);
        chk("t1_s_paddr", 32'(s_paddr), 32'h04);
        chk("t1_s_pwdata", s_pwdata, 32'hDEADBEEF);
        chk("t1_s_pwrite", 32'(s_pwrite), 32'd1);
        chk("t1_gnt", 32'(arb_gnt), 32'h1);
        m0_penable = 1;
        step();                                   // T+2: slave ACCESS
        chk("t1_s_penable_access", 32'(s_penable), 32'd1);
        chk("t1_m0_pready_early", 32'(m0_pready), 32'd0);
        step();                                   // T+3: DONE
        chk("t1_m0_pready", 32'(m0_pready), 32'd1);
        chk("t1_m0_prdata_write", m0_prdata, 32'h0);
        chk("t1_s_psel_done", 32'(s_psel), 32'd0);
        m0_psel = 0; m0_penable = 0;
        step();                                   // T+4: IDLE
        chk("t1_m0_pready_pulse", 32'(m0_pready), 32'd0);
        chk("t1_gnt_idle", 32'(arb_gnt), 32'd0);

        // ---------------- 2: ties and round robin ----------------
        resetn = 0;
        step();
        resetn = 1;
        m0_psel = 1; m0_pwrite = 0; m0_paddr = 8'h10;
        m1_psel = 1; m1_pwrite = 0; m1_paddr = 8'h20;
        s_prdata = 32'h11110000;
        step();                                   // A+1
        chk("t2_gnt_first", 32'(arb_gnt), 32'h1);
        chk("t2_paddr_first", 32'(s_paddr), 32'h10);
        m0_penable = 1; m1_penable = 1;
        step(); step();                           // A+3
        chk("t2_m0_pready", 32'(m0_pready), 32'd1);
        chk("t2_m0_prdata", m0_prdata, 32'h11110000);
        chk("t2_m1_waiting", 32'(m1_pready), 32'd0);
        m0_psel = 0; m0_penable = 0; s_prdata = 32'h22220000;
        step(); step();                           // A+5
        chk("t2_gnt_second", 32'(arb_gnt), 32'h2);
        chk("t2_paddr_second", 32'(s_paddr), 32'h20);
        step(); step();                           // A+7
        chk("t2_m1_pready", 32'(m1_pready), 32'd1);
        chk("t2_m1_prdata", m1_prdata, 32'h22220000);
        chk("t2_m0_prdata_zero", m0_prdata, 32'h0);
        m1_psel = 0; m1_penable = 0;
        step();                                   // A+8: both again, M1 was last
        m0_psel = 1; m0_paddr = 8'h30;
        m1_psel = 1; m1_paddr = 8'h40;
        s_prdata = 32'h33330000;
        step();                                   // A+9
        chk("t2_gnt_third", 32'(arb_gnt), 32'h1);
        chk("t2_paddr_third", 32'(s_paddr), 32'h30);
        m0_penable = 1; m1_penable = 1;
        step(); step();                           // A+11
        chk("t2_m0_pready2", 32'(m0_pready), 32'd1);
        m0_psel = 0; m0_penable = 0;
        step();                                   // A+12: tie again, M0 was last
        m0_psel = 1; m0_paddr = 8'h50;
        step();                                   // A+13
        chk("t2_gnt_fourth", 32'(arb_gnt), 32'h2);
        chk("t2_paddr_fourth", 32'(s_paddr), 32'h40);
        m0_penable = 1;
        step(); step();                           // A+15
        chk("t2_m1_pready2", 32'(m1_pready), 32'd1);
        chk("t2_m0_wait2", 32'(m0_pready), 32'd0);
        m1_psel = 0; m1_penable = 0;
        step(); step();                           // A+17
        chk("t2_gnt_fifth", 32'(arb_gnt), 32'h1);
        chk("t2_paddr_fifth", 32'(s_paddr), 32'h50);
        step(); step();                           // A+19
        chk("t2_m0_pready3", 32'(m0_pready), 32'd1);
        m0_psel = 0; m0_penable = 0;
        step();                                   // IDLE

        // ---------------- 3: M1 read, 3 wait states ----------------
        m1_psel = 1; m1_penable = 0; m1_pwrite = 0; m1_paddr = 8'h08;
        s_pready = 0; s_prdata = 32'h0;
        step();                                   // T+1
        m1_penable = 1;
        for (int i = 0; i < 4; i++) begin         // T+2 .. T+5
            step();
            chk("t3_m1_wait", 32'(m1_pready), 32'd0);
            chk("t3_m0_quiet", 32'(m0_pready), 32'd0);
        end
        s_pready = 1; s_prdata = 32'h5A5A0001;
        step();                                   // T+6
        chk("t3_m1_pready", 32'(m1_pready), 32'd1);
        chk("t3_m1_prdata", m1_prdata, 32'h5A5A0001);
        chk("t3_m0_quiet_done", 32'(m0_pready), 32'd0);
        m1_psel = 0; m1_penable = 0; s_pready = 0; s_prdata = 32'h0;
        step();
        chk("t3_m1_prdata_cleared", m1_prdata, 32'h0);

        // ---------------- 4: slave error ----------------
        m0_psel = 1; m0_penable = 0; m0_pwrite = 1; m0_paddr = 8'h0C; m0_pwdata = 32'h12345678;
        s_pready = 1; s_pslverr = 1;
        step();
        m0_penable = 1;
        step(); step();                           // U+3
        chk("t4_m0_pready", 32'(m0_pready), 32'd1);
        chk("t4_m0_pslverr", 32'(m0_pslverr), 32'd1);
        chk("t4_m1_pslverr", 32'(m1_pslverr), 32'd0);
        m0_psel = 0; m0_penable = 0;
        step();
        chk("t4_m0_pslverr_cleared", 32'(m0_pslverr), 32'd0);
        s_pready = 0; s_pslverr = 0;

        // ---------------- 5: reset during ACCESS ----------------
        m0_psel = 1; m0_penable = 0; m0_pwrite = 0; m0_paddr = 8'h14;
        step();
        m0_penable = 1;
        step();                                   // V+2: ACCESS
        chk("t5_in_access", 32'(s_penable), 32'd1);
        resetn = 0;
        step();                                   // V+3
        chk("t5_s_psel", 32'(s_psel), 32'd0);
        chk("t5_s_penable", 32'(s_penable), 32'd0);
        chk("t5_gnt", 32'(arb_gnt), 32'd0);
        chk("t5_m0_pready", 32'(m0_pready), 32'd0);
        resetn = 1; m0_psel = 0; m0_penable = 0; s_pready = 1;
        step();
        chk("t5_m0_pready_after", 32'(m0_pready), 32'd0);
        chk("t5_s_psel_after", 32'(s_psel), 32'd0);
        s_pready = 0;

        // ---------------- 6: slave never ready ----------------
        m1_psel = 1; m1_penable = 0; m1_pwrite = 0; m1_paddr = 8'h18;
        s_pready = 0; s_prdata = 32'hFFFF0000;
        step();                                   // W+1
        m1_penable = 1;
`ifdef APB_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin        // W+2 .. W+17
            step();
            seen = seen | m1_pready;
        end
        chk("t6_no_early_pready", 32'(seen), 32'd0);
        chk("t6_still_access", 32'(s_penable), 32'd1);
        step();                                   // W+18: forced DONE
        chk("t6_m1_pready", 32'(m1_pready), 32'd1);
        chk("t6_m1_pslverr", 32'(m1_pslverr), 32'd1);
        chk("t6_m1_prdata", m1_prdata, 32'h0);
        chk("t6_s_psel_dropped", 32'(s_psel), 32'd0);
        m1_psel = 0; m1_penable = 0;
        step();
`else
        for (int i = 0; i < 1000; i++) begin
            step();
            seen = seen | m1_pready;
        end
        chk("t6_no_pready", 32'(seen), 32'd0);
        chk("t6_s_psel_held", 32'(s_psel), 32'd1);
        chk("t6_s_penable_held", 32'(s_penable), 32'd1);
        chk("t6_gnt_held", 32'(arb_gnt), 32'h2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
